// File: rtl/bht_if.sv
// Signal bundle between the IF/EX pipeline and the branch history table.
// The master side drives PCs, hazard controls and branch resolution; the
// slave side (the predictor) returns predictions, recovery info and stats.
interface bht_if;
   logic [31:0] CurrentPC;
   logic        BTBhit;
   logic [31:0] PrePC;
   logic        StallD;
   logic        FlushD;
   logic        StallE;
   logic        FlushE;
   logic        IsBranchE;
   logic        BranchE;
   logic [31:0] EXpc;
   logic [31:0] BrNPC;
   logic        PredTakenF;
   logic [31:0] PredNPC;
   logic        PredTakenE;
   logic        MispredE;
   logic [31:0] CorrectPC;
   logic [31:0] BrCount;
   logic [31:0] MissCount;

   modport master (
      output CurrentPC, BTBhit, PrePC, StallD, FlushD, StallE, FlushE,
             IsBranchE, BranchE, EXpc, BrNPC,
      input  PredTakenF, PredNPC, PredTakenE, MispredE, CorrectPC,
             BrCount, MissCount
   );

   modport slave (
      input  CurrentPC, BTBhit, PrePC, StallD, FlushD, StallE, FlushE,
             IsBranchE, BranchE, EXpc, BrNPC,
      output PredTakenF, PredNPC, PredTakenE, MispredE, CorrectPC,
             BrCount, MissCount
   );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table placed behind the BTB in fetch. A 2-bit saturating
// counter per entry qualifies the BTB hit to choose the fetch next-PC; the
// prediction rides along to EX where the branch outcome trains the counter,
// mispredictions are flagged and the recovery PC is produced.
module bht_predictor #(
   parameter int         IDX_W   = 4,
   parameter logic [1:0] CNT_RST = 2'b01
) (
   input logic clk,
   input logic rst,
   bht_if.slave bus
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0]       cnt [ENTRIES];
   logic             predD;
   logic             predE;
   logic [IDX_W-1:0] idxF;
   logic [IDX_W-1:0] idxE;
   logic             updE;
   logic             predTakenF;
   logic             mispredE;

   // Counter moves one step toward strongly-taken, sticking at 11.
   function automatic logic [1:0] satInc2(input logic [1:0] v);
      return (v == 2'b11) ? v : v + 2'b01;
   endfunction

   // Counter moves one step toward strongly-not-taken, sticking at 00.
   function automatic logic [1:0] satDec2(input logic [1:0] v);
      return (v == 2'b00) ? v : v - 2'b01;
   endfunction

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] satAdd32(input logic [31:0] v, input logic inc);
      return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction

   assign idxF = bus.CurrentPC[IDX_W+1:2];
   assign idxE = bus.EXpc[IDX_W+1:2];

   // Only a real branch that actually leaves EX this cycle trains or counts.
   assign updE = bus.IsBranchE & ~bus.StallE & ~bus.FlushE;

   // Fetch: counter MSB gates the BTB hit; no bypass from a same-cycle update.
   assign predTakenF     = bus.BTBhit & cnt[idxF][1];
   assign bus.PredTakenF = predTakenF;
   assign bus.PredNPC    = predTakenF ? bus.PrePC : bus.CurrentPC + 32'd4;

   // Resolve: a predicted-taken non-branch is also a misprediction.
   assign mispredE      = bus.IsBranchE ? (bus.BranchE ^ predE) : predE;
   assign bus.MispredE  = mispredE;
   assign bus.PredTakenE = predE;
   assign bus.CorrectPC = (bus.IsBranchE & bus.BranchE) ? bus.BrNPC : bus.EXpc + 32'd4;

   // Pattern table: trained on every resolved branch, BTB hit or not.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt[i] <= CNT_RST;
      end else if (updE) begin
         cnt[idxE] <= bus.BranchE ? satInc2(cnt[idxE]) : satDec2(cnt[idxE]);
      end
   end

   // Prediction pipeline IF->ID->EX; flush wins over stall in each register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         predD <= 1'b0;
         predE <= 1'b0;
      end else begin
         if (bus.FlushD)       predD <= 1'b0;
         else if (!bus.StallD) predD <= predTakenF;
         if (bus.FlushE)       predE <= 1'b0;
         else if (!bus.StallE) predE <= predD;
      end
   end

   // Branch and misprediction statistics, same enable as the table update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.BrCount   <= 32'd0;
         bus.MissCount <= 32'd0;
      end else if (updE) begin
         bus.BrCount   <= satAdd32(bus.BrCount, 1'b1);
         bus.MissCount <= satAdd32(bus.MissCount, mispredE);
      end
   end

endmodule
